// File: rtl/rvv_alu_seq.sv
// Element/chunk sequencer around rvv_alu: walks every active element and lane-sized
// chunk, captures each ALU result chunk into a VLEN-wide buffer, then pulses done.
module rvv_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      vl,
  input  logic [2:0]      vsew,
  input  logic [VLEN-1:0] vd_old,
  input  logic [63:0]     alu_vd,
  input  logic [9:0]      alu_index,
  output logic            alu_run,
  output logic [9:0]      alu_byte_i,
  output logic [3:0]      alu_in_reg_offset,
  output logic            busy,
  output logic            done,
  output logic [VLEN-1:0] vd_out,
  output logic            err
);

  localparam logic [31:0] LANE_W = 32'(LANE_WIDTH);
  localparam logic [31:0] LW     = 32'd1 << LANE_W;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  vsew_reg;
  logic [7:0]  vl_eff_reg;
  logic [9:0]  elem_reg;
  logic [3:0]  chunk_reg;

  logic [31:0] vlmax_in;
  logic [7:0]  vl_eff_in;
  logic [31:0] sew_bits;
  logic [3:0]  ch_last;
  logic [6:0]  w;
  logic [63:0] lane_mask;
  logic [11:0] idx_end;
  logic        oob;
  logic        last;
  logic [VLEN-1:0] wr_mask, wr_data, vd_write;

  // Effective vector length for the request being presented on the start cycle.
  always_comb begin
    vlmax_in  = 32'(VLEN) >> (32'(vsew) + 32'd3);
    vl_eff_in = vl;
    if (32'(vl) > vlmax_in) vl_eff_in = vlmax_in[7:0];
  end

  // Chunk count and chunk write width for the latched element width.
  always_comb begin
    sew_bits = 32'd8 << vsew_reg;
    ch_last  = 4'd0;
    if (32'(vsew_reg) + 32'd3 > LANE_W)
      ch_last = 4'((32'd1 << (32'(vsew_reg) + 32'd3 - LANE_W)) - 32'd1);
    w         = (sew_bits < LW) ? 7'(sew_bits) : 7'(LW);
    lane_mask = (w >= 7'd64) ? '1 : ((64'd1 << w) - 64'd1);
  end

  // Same-cycle capture of the ALU chunk at its bit index; out-of-range chunks are dropped.
  always_comb begin
    idx_end  = {2'b00, alu_index} + 12'(w);
    oob      = idx_end > 12'(VLEN);
    wr_mask  = VLEN'(lane_mask) << alu_index;
    wr_data  = VLEN'(alu_vd & lane_mask) << alu_index;
    vd_write = (vd_out & ~wr_mask) | wr_data;
    last     = (elem_reg == {2'b00, vl_eff_reg - 8'd1}) && (chunk_reg == ch_last);
  end

  always_comb begin
    state_next        = state_reg;
    alu_run           = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    alu_byte_i        = elem_reg;
    alu_in_reg_offset = chunk_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (vsew > 3'd3)            state_next = FIN;
          else if (vl_eff_in == 8'd0) state_next = FIN;
          else                        state_next = RUN;
        end
      end
      RUN: begin
        alu_run = 1'b1;
        busy    = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      vsew_reg   <= 3'd0;
      vl_eff_reg <= 8'd0;
      elem_reg   <= 10'd0;
      chunk_reg  <= 4'd0;
      vd_out     <= '0;
      err        <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            vsew_reg   <= vsew;
            vl_eff_reg <= vl_eff_in;
            vd_out     <= vd_old;
            err        <= (vsew > 3'd3);
            elem_reg   <= 10'd0;
            chunk_reg  <= 4'd0;
          end
        end
        RUN: begin
          if (oob) err <= 1'b1;
          else     vd_out <= vd_write;
          if (chunk_reg == ch_last) begin
            chunk_reg <= 4'd0;
            elem_reg  <= elem_reg + 10'd1;
          end else begin
            chunk_reg <= chunk_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Self-checking bench for rvv_alu_seq: directed vector table, corner sequences and a
// randomized run compared against an element-by-element placement model.
module tb_rvv_alu_seq;

  localparam int VLEN       = 128;
  localparam int LANE_WIDTH = 3;

  localparam int M_BYTE = 0;  // vd = byte_i + 0x10, index = byte_i*8
  localparam int M_OFFS = 1;  // vd = offset, index = byte_i*32 + offset*8
  localparam int M_NAT  = 2;  // vd = offset, index = byte_i*64 + offset*8
  localparam int M_F124 = 3;  // vd = 0xAB, index = 124
  localparam int M_F120 = 4;  // vd = 0x5A, index = 120
  localparam int M_RAND = 5;  // hashed vd, natural placement for rand_sew

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      vl_in = '0;
  logic [2:0]      vsew_in = '0;
  logic [VLEN-1:0] vd_old_in = '0;
  logic [63:0]     alu_vd;
  logic [9:0]      alu_index;
  logic            alu_run;
  logic [9:0]      alu_byte_i;
  logic [3:0]      alu_in_reg_offset;
  logic            busy;
  logic            done;
  logic [VLEN-1:0] vd_out;
  logic            err;

  int          mode = M_BYTE;
  int          rand_sew = 8;
  logic [63:0] rand_salt = '0;
  int          tests = 0;
  int          fails = 0;

  rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl_in), .vsew(vsew_in),
    .vd_old(vd_old_in), .alu_vd(alu_vd), .alu_index(alu_index),
    .alu_run(alu_run), .alu_byte_i(alu_byte_i), .alu_in_reg_offset(alu_in_reg_offset),
    .busy(busy), .done(done), .vd_out(vd_out), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] stub_val(input int e, input int c, input logic [63:0] salt);
    return (64'(e) * 64'h9E3779B97F4A7C15) ^ (64'(c) * 64'hC2B2AE3D27D4EB4F) ^ salt;
  endfunction

  // Stub ALU: combinational response to the sequencer's element/chunk outputs.
  always_comb begin
    alu_vd    = '0;
    alu_index = '0;
    case (mode)
      M_BYTE: begin alu_vd = 64'(alu_byte_i) + 64'h10; alu_index = 10'(int'(alu_byte_i) * 8); end
      M_OFFS: begin alu_vd = 64'(alu_in_reg_offset);
                    alu_index = 10'(int'(alu_byte_i) * 32 + int'(alu_in_reg_offset) * 8); end
      M_NAT:  begin alu_vd = 64'(alu_in_reg_offset);
                    alu_index = 10'(int'(alu_byte_i) * 64 + int'(alu_in_reg_offset) * 8); end
      M_F124: begin alu_vd = 64'hAB; alu_index = 10'd124; end
      M_F120: begin alu_vd = 64'h5A; alu_index = 10'd120; end
      default: begin
        alu_vd    = stub_val(int'(alu_byte_i), int'(alu_in_reg_offset), rand_salt);
        alu_index = 10'(int'(alu_byte_i) * rand_sew + int'(alu_in_reg_offset) * 8);
      end
    endcase
  end

  task automatic chk(input string nm, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference: place every active element's chunks at their stub index, keeping vd_old elsewhere.
  task automatic model(input logic [2:0] sv, input logic [7:0] vlv, input logic [VLEN-1:0] old,
                       output logic [VLEN-1:0] vd, output logic e_err, output int cyc);
    int sew, vlmax, vle, ch, w, idx;
    logic [63:0] val;
    vd = old; e_err = 1'b0; cyc = 1;
    if (sv > 3) begin e_err = 1'b1; return; end
    sew   = 8 << sv;
    vlmax = VLEN / sew;
    vle   = (int'(vlv) < vlmax) ? int'(vlv) : vlmax;
    ch    = (sew > 8) ? sew / 8 : 1;
    w     = (sew < 8) ? sew : 8;
    for (int e = 0; e < vle; e++)
      for (int c = 0; c < ch; c++) begin
        idx = e * sew + c * 8;
        val = stub_val(e, c, rand_salt);
        if (idx + w > VLEN) e_err = 1'b1;
        else for (int b = 0; b < w; b++) vd[idx + b] = val[b];
      end
    cyc = 1 + vle * ch;
  endtask

  task automatic run_op(input string tag, input logic [2:0] sv, input logic [7:0] vlv, input int md,
                        input logic [VLEN-1:0] old, input logic noise,
                        input logic [VLEN-1:0] exp_vd, input logic exp_err, input int exp_cyc);
    int cyc = 0, runs = 0, ch, s;
    bit seen = 0;
    s  = int'(sv);
    ch = (s + 3 > LANE_WIDTH) ? (1 << (s + 3 - LANE_WIDTH)) : 1;
    @(negedge clk);
    mode = md; vsew_in = sv; vl_in = vlv; vd_old_in = old; start = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (alu_run && s <= 3) begin
        chk({tag, " elem"}, VLEN'(alu_byte_i), VLEN'(runs / ch));
        chk({tag, " chunk"}, VLEN'(alu_in_reg_offset), VLEN'(runs % ch));
        runs++;
      end
      if (done) begin
        seen = 1;
        chk({tag, " latency"}, VLEN'(cyc), VLEN'(exp_cyc));
        chk({tag, " run_cycles"}, VLEN'(runs), VLEN'(exp_cyc - 1));
        chk({tag, " vd_out"}, vd_out, exp_vd);
        chk({tag, " err"}, VLEN'(err), VLEN'(exp_err));
        chk({tag, " busy_at_done"}, VLEN'(busy), VLEN'(1));
      end
      if (noise) begin
        if (done) start = 1'b1;
        else if (cyc == 2) begin start = 1'b1; vsew_in = 3'd0; vl_in = 8'd1; vd_old_in = '0; end
        else if (cyc == 3) start = 1'b0;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done after %0d cycles, expected %0d", tag, cyc, exp_cyc);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_pulse"}, VLEN'(done), VLEN'(0));
    chk({tag, " idle_after"}, VLEN'(busy), VLEN'(0));
    chk({tag, " vd_hold"}, vd_out, exp_vd);
    chk({tag, " err_hold"}, VLEN'(err), VLEN'(exp_err));
    $display("[TB] op %s vsew=%0d vl=%0d cycles=%0d err=%0b", tag, sv, vlv, cyc, err);
  endtask

  typedef struct {
    string           tag;
    logic [2:0]      sv;
    logic [7:0]      vlv;
    int              md;
    logic [VLEN-1:0] old;
    logic            noise;
    logic [VLEN-1:0] exp_vd;
    logic            exp_err;
    int              exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [VLEN-1:0] ones, pat, m_vd;
    logic m_err;
    int m_cyc, runs, dones;
    logic [2:0] rsv;
    logic [7:0] rvl;
    logic [VLEN-1:0] rold;
    ones = '1;
    pat  = 128'h0123456789ABCDEF_FEDCBA9876543210;

    vecs[0] = '{"byte4",   3'd0, 8'd4,   M_BYTE, ones, 1'b0, {ones[127:32], 32'h13121110}, 1'b0, 5};
    vecs[1] = '{"offs2",   3'd2, 8'd2,   M_OFFS, ones, 1'b0, {ones[127:64], 64'h03020100_03020100}, 1'b0, 9};
    vecs[2] = '{"vl200",   3'd3, 8'd200, M_NAT,  ones, 1'b0, {64'h0706050403020100, 64'h0706050403020100}, 1'b0, 17};
    vecs[3] = '{"vl0",     3'd1, 8'd0,   M_BYTE, pat,  1'b0, pat, 1'b0, 1};
    vecs[4] = '{"vsew5",   3'd5, 8'd4,   M_BYTE, pat,  1'b0, pat, 1'b1, 1};
    vecs[5] = '{"idx124",  3'd0, 8'd1,   M_F124, pat,  1'b0, pat, 1'b1, 2};
    vecs[6] = '{"idx120",  3'd0, 8'd1,   M_F120, ones, 1'b0, {8'h5A, ones[119:0]}, 1'b0, 2};
    vecs[7] = '{"vl20",    3'd0, 8'd20,  M_BYTE, '0,   1'b0, 128'h1F1E1D1C1B1A19181716151413121110, 1'b0, 17};
    vecs[8] = '{"noise",   3'd2, 8'd2,   M_OFFS, ones, 1'b1, {ones[127:64], 64'h03020100_03020100}, 1'b0, 9};

    repeat (3) @(negedge clk);
    chk("reset busy", VLEN'(busy), '0);
    chk("reset done", VLEN'(done), '0);
    chk("reset run", VLEN'(alu_run), '0);
    chk("reset byte_i", VLEN'(alu_byte_i), '0);
    chk("reset offset", VLEN'(alu_in_reg_offset), '0);
    chk("reset err", VLEN'(err), '0);
    chk("reset vd_out", vd_out, '0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].tag, vecs[i].sv, vecs[i].vlv, vecs[i].md, vecs[i].old, vecs[i].noise,
             vecs[i].exp_vd, vecs[i].exp_err, vecs[i].exp_cyc);

    // Reset asserted during the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    mode = M_BYTE; vsew_in = 3'd0; vl_in = 8'd8; vd_old_in = ones; start = 1'b1;
    runs = 0;
    for (int k = 0; k < 20 && runs < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (alu_run) runs++;
    end
    chk("abort reached run3", VLEN'(runs), VLEN'(3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", VLEN'(busy), '0);
    chk("abort vd_out", vd_out, '0);
    chk("abort done", VLEN'(done), '0);
    chk("abort run", VLEN'(alu_run), '0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort quiet", VLEN'(dones), '0);
    run_op("after_abort", 3'd0, 8'd4, M_BYTE, ones, 1'b0, {ones[127:32], 32'h13121110}, 1'b0, 5);

    // Randomized operations against the placement model.
    for (int t = 0; t < 40; t++) begin
      rsv = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rvl = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      rold = {$urandom, $urandom, $urandom, $urandom};
      rand_salt = {$urandom, $urandom};
      rand_sew = 8 << rsv;
      model(rsv, rvl, rold, m_vd, m_err, m_cyc);
      run_op($sformatf("rand%0d", t), rsv, rvl, M_RAND, rold, 1'($urandom_range(0, 3) == 0),
             m_vd, m_err, m_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
